otter_pipe_ctrl: RTL

Pipeline control sequencer for the 5-stage OTTER core; it consumes the hazard-detection outputs and turns them into per-stage register actions. Inputs are load-use stall, EX-resolved branch redirect, and instruction/data memory ready. Outputs are enables and bubble/flush controls for PC, FE_DE, DE_EX, EX_MEM and MEM_WB. It tracks multi-cycle data-memory waits with a state machine and timeout, and keeps saturating stall/flush performance counters.

---
 rtl/otter_pipe_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/otter_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// otter_pipe_ctrl
//   Pipeline control sequencer for the 5-stage OTTER core. It takes the
//   hazard-unit outputs and produces per-stage register actions. It also
//   tracks multi-cycle data-memory waits with a timeout and keeps saturating
//   stall/flush performance counters.
//
// Parameters
//   DMEM_TIMEOUT : max consecutive DWAIT cycles before HALT (0 = never halt)
//   CNT_W        : width of the performance counters
//
// Ports
//   CLK, RST            : clock, synchronous active-high reset
//   LOAD_USE            : load-use hazard on the decode instruction
//   BR_TAKEN            : taken branch/jump resolved in EX
//   IMEM_READY          : fetch data valid this cycle
//   DMEM_REQ/DMEM_READY : MEM-stage data access and its completion
//   PC_EN ... MEM_WB_*  : per-stage enables and NOP-insert controls
//   HALTED              : core halted on a data-memory timeout
//   STALL_CNT/FLUSH_CNT : saturating stall-cycle / redirect counters
// ---------------------------------------------------------------------------
module otter_pipe_ctrl #(
    parameter int unsigned DMEM_TIMEOUT = 16,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             LOAD_USE,
    input  logic             BR_TAKEN,
    input  logic             IMEM_READY,
    input  logic             DMEM_REQ,
    input  logic             DMEM_READY,
    output logic             PC_EN,
    output logic             FE_DE_EN,
    output logic             FE_DE_FLUSH,
    output logic             DE_EX_EN,
    output logic             DE_EX_BUBBLE,
    output logic             EX_MEM_EN,
    output logic             MEM_WB_EN,
    output logic             MEM_WB_BUBBLE,
    output logic             HALTED,
    output logic [CNT_W-1:0] STALL_CNT,
    output logic [CNT_W-1:0] FLUSH_CNT
);

    // A zero-width timer is illegal, so a disabled timeout still gets one bit.
    localparam int unsigned TMR_W = (DMEM_TIMEOUT == 0) ? 1 : $clog2(DMEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DWAIT = 2'd1,
        S_HALT  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [CNT_W-1:0]   stall_q, flush_q;
    logic               stall_inc, flush_inc;
    logic               upstream;   // apply the redirect / load-use / fetch rules

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_RUN;
            timer_q <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            if (stall_inc && (stall_q != '1)) stall_q <= stall_q + 1'b1;
            if (flush_inc && (flush_q != '1)) flush_q <= flush_q + 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        stall_inc     = 1'b0;
        flush_inc     = 1'b0;
        upstream      = 1'b0;
        PC_EN         = 1'b1;
        FE_DE_EN      = 1'b1;
        FE_DE_FLUSH   = 1'b0;
        DE_EX_EN      = 1'b1;
        DE_EX_BUBBLE  = 1'b0;
        EX_MEM_EN     = 1'b1;
        MEM_WB_EN     = 1'b1;
        MEM_WB_BUBBLE = 1'b0;
        HALTED        = 1'b0;

        case (state_q)
            S_RUN: begin
                if (DMEM_REQ && !DMEM_READY) begin
                    // Freeze everything up to EX_MEM. The held EX instruction
                    // re-presents any branch/hazard once memory completes.
                    PC_EN         = 1'b0;
                    FE_DE_EN      = 1'b0;
                    DE_EX_EN      = 1'b0;
                    EX_MEM_EN     = 1'b0;
                    MEM_WB_BUBBLE = 1'b1;
                    stall_inc     = 1'b1;
                    timer_d       = TMR_W'(1);
                    state_d       = S_DWAIT;
                end else begin
                    upstream = 1'b1;
                end
            end
            S_DWAIT: begin
                if (!DMEM_READY) begin
                    PC_EN         = 1'b0;
                    FE_DE_EN      = 1'b0;
                    DE_EX_EN      = 1'b0;
                    EX_MEM_EN     = 1'b0;
                    MEM_WB_BUBBLE = 1'b1;
                    stall_inc     = 1'b1;
                    if (timer_q != '1) timer_d = timer_q + 1'b1;
                    if ((DMEM_TIMEOUT != 0) && (timer_q == TMR_W'(DMEM_TIMEOUT)))
                        state_d = S_HALT;
                end else begin
                    // Data returns: MEM_WB takes real data, upstream acts as in RUN.
                    upstream = 1'b1;
                    timer_d  = '0;
                    state_d  = S_RUN;
                end
            end
            S_HALT: begin
                PC_EN     = 1'b0;
                FE_DE_EN  = 1'b0;
                DE_EX_EN  = 1'b0;
                EX_MEM_EN = 1'b0;
                MEM_WB_EN = 1'b0;
                HALTED    = 1'b1;
            end
            default: state_d = S_RUN;
        endcase

        // Redirect outranks load-use and fetch misses: decode/fetch are wrong-path.
        if (upstream) begin
            if (BR_TAKEN) begin
                FE_DE_FLUSH  = 1'b1;
                DE_EX_BUBBLE = 1'b1;
                flush_inc    = 1'b1;
            end else if (LOAD_USE) begin
                PC_EN        = 1'b0;
                FE_DE_EN     = 1'b0;
                DE_EX_BUBBLE = 1'b1;
                stall_inc    = 1'b1;
            end else if (!IMEM_READY) begin
                PC_EN        = 1'b0;
                FE_DE_FLUSH  = 1'b1;
                stall_inc    = 1'b1;
            end
        end

        // Reset drains NOPs through the whole pipe with the PC held.
        if (RST) begin
            state_d       = S_RUN;
            timer_d       = '0;
            stall_inc     = 1'b0;
            flush_inc     = 1'b0;
            PC_EN         = 1'b0;
            FE_DE_EN      = 1'b1;
            FE_DE_FLUSH   = 1'b1;
            DE_EX_EN      = 1'b1;
            DE_EX_BUBBLE  = 1'b1;
            EX_MEM_EN     = 1'b1;
            MEM_WB_EN     = 1'b1;
            MEM_WB_BUBBLE = 1'b1;
            HALTED        = 1'b0;
        end
    end

    assign STALL_CNT = stall_q;
    assign FLUSH_CNT = flush_q;

endmodule
